// File: rtl/matrix_multiplier_pkg.sv
// Shared widths and arithmetic helpers for the colour-matrix datapath.
package matrix_multiplier_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int MSIZE_DEF = 9;
  localparam int FRAC_DEF  = MSIZE_DEF - 2;

  // Sign-magnitude to two's complement; negative zero decodes to 0.
  function automatic logic signed [31:0] sm_decode(input logic [31:0] raw, input int msize);
    logic [31:0] mag;
    mag = raw & ((32'd1 << (msize - 1)) - 32'd1);
    return raw[msize-1] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic [31:0] sat_u(input logic signed [31:0] q, input int dsize);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< dsize) - 32'sd1;
    if (q < 32'sd0) return '0;
    if (q > hi) return $unsigned(hi);
    return $unsigned(q);
  endfunction

endpackage

// File: rtl/matrix_multiplier_if.sv
// Pixel, coefficient and result bundle for the colour-matrix stage.
interface matrix_multiplier_if import matrix_multiplier_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int MSIZE = MSIZE_DEF
);
  logic [DSIZE-1:0] iR, iG, iB;
  logic [MSIZE-1:0] M00, M01, M02;
  logic [MSIZE-1:0] M10, M11, M12;
  logic [MSIZE-1:0] M20, M21, M22;
  logic [DSIZE-1:0] Ro, Go, Bo;

  modport master (
    output iR, iG, iB,
    output M00, M01, M02, M10, M11, M12, M20, M21, M22,
    input  Ro, Go, Bo
  );

  modport slave (
    input  iR, iG, iB,
    input  M00, M01, M02, M10, M11, M12, M20, M21, M22,
    output Ro, Go, Bo
  );
endinterface

// File: rtl/matrix_multiplier_row_mac.sv
// One output channel: three products, row sum, round-half-up and saturate,
// three register stages deep.
module matrix_row_mac import matrix_multiplier_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int MSIZE = MSIZE_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] pix_r,
  input  logic [DSIZE-1:0] pix_g,
  input  logic [DSIZE-1:0] pix_b,
  input  logic [MSIZE-1:0] coef_r,
  input  logic [MSIZE-1:0] coef_g,
  input  logic [MSIZE-1:0] coef_b,
  output logic [DSIZE-1:0] y
);

  localparam int PW = DSIZE + MSIZE;
  localparam int AW = PW + 2;
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (FRAC - 1));

  logic signed [MSIZE-1:0] coef_d [3];
  logic signed [MSIZE-1:0] coef_q [3];
  logic        [DSIZE-1:0] pix_d  [3];
  logic        [DSIZE-1:0] pix_q  [3];
  logic signed [PW-1:0]    prod   [3];
  logic signed [AW-1:0]    sum_d, sum_q, rnd;
  logic        [DSIZE-1:0] y_d, y_q;

  assign y = y_q;

  always_comb begin
    coef_d[0] = MSIZE'(sm_decode(32'(coef_r), MSIZE));
    coef_d[1] = MSIZE'(sm_decode(32'(coef_g), MSIZE));
    coef_d[2] = MSIZE'(sm_decode(32'(coef_b), MSIZE));
    pix_d[0]  = pix_r;
    pix_d[1]  = pix_g;
    pix_d[2]  = pix_b;

    // Pixel is zero-extended so it stays positive in the signed product.
    sum_d = '0;
    for (int i = 0; i < 3; i++) begin
      prod[i] = $signed({{DSIZE{coef_q[i][MSIZE-1]}}, coef_q[i]}) *
                $signed({{MSIZE{1'b0}}, pix_q[i]});
      sum_d   = sum_d + AW'(prod[i]);
    end

    rnd = sum_q + HALF;
    y_d = DSIZE'(sat_u(32'(rnd >>> FRAC), DSIZE));
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        coef_q[i] <= '0;
        pix_q[i]  <= '0;
      end
      sum_q <= '0;
      y_q   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        coef_q[i] <= coef_d[i];
        pix_q[i]  <= pix_d[i];
      end
      sum_q <= sum_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: rtl/matrix_multiplier.sv
// 3x3 colour-matrix multiplier: fans the pixel and coefficient rows out to
// one row MAC per output channel.
module matrix_multiplier import matrix_multiplier_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int MSIZE = MSIZE_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input logic               clock,
  input logic               rst,
  matrix_multiplier_if.slave bus
);

  matrix_row_mac #(.DSIZE(DSIZE), .MSIZE(MSIZE), .FRAC(FRAC)) u_row_r (
    .clock(clock), .rst(rst),
    .pix_r(bus.iR), .pix_g(bus.iG), .pix_b(bus.iB),
    .coef_r(bus.M00), .coef_g(bus.M01), .coef_b(bus.M02),
    .y(bus.Ro)
  );

  matrix_row_mac #(.DSIZE(DSIZE), .MSIZE(MSIZE), .FRAC(FRAC)) u_row_g (
    .clock(clock), .rst(rst),
    .pix_r(bus.iR), .pix_g(bus.iG), .pix_b(bus.iB),
    .coef_r(bus.M10), .coef_g(bus.M11), .coef_b(bus.M12),
    .y(bus.Go)
  );

  matrix_row_mac #(.DSIZE(DSIZE), .MSIZE(MSIZE), .FRAC(FRAC)) u_row_b (
    .clock(clock), .rst(rst),
    .pix_r(bus.iR), .pix_g(bus.iG), .pix_b(bus.iB),
    .coef_r(bus.M20), .coef_g(bus.M21), .coef_b(bus.M22),
    .y(bus.Bo)
  );

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed and random streaming bench for matrix_multiplier at default widths.
module tb_matrix_multiplier;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  matrix_multiplier_if bus ();

  matrix_multiplier dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected results in flight: entry 2 is due at the next check.
  int    h_r [3];
  int    h_g [3];
  int    h_b [3];
  string h_tag [3];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_ch(input logic [8:0] m0, input logic [8:0] m1, input logic [8:0] m2,
                                input int r, input int g, input int b);
    int c0, c1, c2, s, q;
    c0 = m0[8] ? -int'(m0[7:0]) : int'(m0[7:0]);
    c1 = m1[8] ? -int'(m1[7:0]) : int'(m1[7:0]);
    c2 = m2[8] ? -int'(m2[7:0]) : int'(m2[7:0]);
    s  = c0 * r + c1 * g + c2 * b;
    q  = (s + 64) >>> 7;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  // mf packs {M22,M21,M20,M12,M11,M10,M02,M01,M00}, M00 in the low 9 bits.
  task automatic step(input bit rst_v, input logic [80:0] mf, input int r, input int g, input int b,
                      input int er, input int eg, input int eb, input string tag);
    @(negedge clock);
    chk({h_tag[2], "_R"}, int'(bus.Ro), h_r[2]);
    chk({h_tag[2], "_G"}, int'(bus.Go), h_g[2]);
    chk({h_tag[2], "_B"}, int'(bus.Bo), h_b[2]);
    for (int i = 2; i > 0; i--) begin
      h_r[i] = h_r[i-1]; h_g[i] = h_g[i-1]; h_b[i] = h_b[i-1]; h_tag[i] = h_tag[i-1];
    end
    h_r[0] = er; h_g[0] = eg; h_b[0] = eb; h_tag[0] = tag;
    if (rst_v) begin
      for (int i = 0; i < 3; i++) begin
        h_r[i] = 0; h_g[i] = 0; h_b[i] = 0; h_tag[i] = "rst_flush";
      end
    end
    rst     = rst_v;
    bus.iR  = 8'(r);
    bus.iG  = 8'(g);
    bus.iB  = 8'(b);
    bus.M00 = mf[8:0];   bus.M01 = mf[17:9];  bus.M02 = mf[26:18];
    bus.M10 = mf[35:27]; bus.M11 = mf[44:36]; bus.M12 = mf[53:45];
    bus.M20 = mf[62:54]; bus.M21 = mf[71:63]; bus.M22 = mf[80:72];
  endtask

  task automatic rand_step(input bit rst_v, input string tag);
    logic [80:0] mf;
    int r, g, b;
    for (int i = 0; i < 9; i++) mf[9*i +: 9] = 9'($urandom_range(0, 511));
    r = $urandom_range(0, 255);
    g = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    step(rst_v, mf, r, g, b,
         ref_ch(mf[8:0],   mf[17:9],  mf[26:18], r, g, b),
         ref_ch(mf[35:27], mf[44:36], mf[53:45], r, g, b),
         ref_ch(mf[62:54], mf[71:63], mf[80:72], r, g, b), tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      h_r[i] = 0; h_g[i] = 0; h_b[i] = 0; h_tag[i] = "reset";
    end
    bus.iR = '0; bus.iG = '0; bus.iB = '0;
    bus.M00 = '0; bus.M01 = '0; bus.M02 = '0;
    bus.M10 = '0; bus.M11 = '0; bus.M12 = '0;
    bus.M20 = '0; bus.M21 = '0; bus.M22 = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 81'd0, 0, 0, 0, 0, 0, 0, "reset");

    step(1'b0, {9'd128, 9'd0, 9'd0, 9'd0, 9'd128, 9'd0, 9'd0, 9'd0, 9'd128},
         10, 20, 30, 10, 20, 30, "identity");
    step(1'b0, {9{9'd511}}, 255, 255, 255, 0, 0, 0, "neg_sat");
    step(1'b0, {9{9'd255}}, 255, 255, 255, 255, 255, 255, "pos_sat");
    step(1'b0, {72'd0, 9'd64}, 3, 0, 0, 2, 0, 0, "round_3");
    step(1'b0, {72'd0, 9'd64}, 1, 0, 0, 1, 0, 0, "round_1");
    step(1'b0, {9'd0, 9'd0, 9'd0, 9'd0, 9'd256, 9'd0, 9'd0, 9'd0, 9'd256},
         200, 77, 0, 0, 0, 0, "neg_zero");
    step(1'b0, {9'd384, 9'd0, 9'd0, 9'd0, 9'd0, 9'd128, 9'd0, 9'd128, 9'd0},
         50, 100, 7, 100, 50, 0, "mixing");
    step(1'b0, {72'd0, 9'd255}, 255, 0, 0, 255, 0, 0, "max_coef");
    step(1'b0, {72'd0, 9'd320}, 1, 0, 0, 0, 0, 0, "neg_half");

    for (int i = 0; i < 5000; i++) rand_step(1'b0, "random");
    rand_step(1'b1, "mid_rst");
    rand_step(1'b0, "post_rst");
    for (int i = 0; i < 5000; i++) rand_step(1'b0, "random");

    for (int i = 0; i < 3; i++) step(1'b0, 81'd0, 0, 0, 0, 0, 0, 0, "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_multiplier.md
# matrix_multiplier

Fully pipelined 3×3 colour-matrix multiplier for the RGB processing chain. Each clock it accepts one RGB pixel and nine sign-magnitude coefficients, and computes the matrix–vector product. It returns one rounded, saturated RGB pixel per clock, three cycles later. It has no handshake and no stall: a streaming datapath stage.

## Interface
- DSIZE, 8: width of each unsigned colour component, in and out.
- MSIZE, 9: width of each coefficient. Bit MSIZE-1 is the sign (1 = negative); bits MSIZE-2:0 are the magnitude.
- FRAC, MSIZE-2 (= 7): fractional bits of the coefficient magnitude, so coefficient value = ±mag / 2^FRAC (1.0 = 128 at defaults).
- clock  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- iR, iG, iB  in  DSIZE each  unsigned input pixel.
- M00..M22  in  MSIZE each  coefficients; Mrc is row r (0 = R, 1 = G, 2 = B out), column c (0 = R, 1 = G, 2 = B in).
- Ro, Go, Bo  out  DSIZE each  unsigned result pixel, registered.

## Operation
- Coefficient decode: SMrc = sign ? -mag : +mag.
  - Sign 1 with magnitude 0 (negative zero) equals 0.
  - Full coefficient range is ±(2^(MSIZE-1)-1).
- Row sum: S_r = SMr0·iR + SMr1·iG + SMr2·iB, exact signed arithmetic.
  - Each product fits in DSIZE+MSIZE signed bits.
  - The accumulator is DSIZE+MSIZE+2 signed bits (11+8 = 19 at defaults); no intermediate truncation.
- Scale and round: Q_r = (S_r + 2^(FRAC-1)) >>> FRAC, arithmetic shift. This is round-half-up.
- Saturate:
  - Q_r < 0 gives 0.
  - Q_r > 2^DSIZE-1 gives 2^DSIZE-1.
  - Otherwise Q_r.
- Output mapping: Ro = row 0, Go = row 1, Bo = row 2.
- Inputs and coefficients are sampled together every cycle. A coefficient change applies only to the pixel sampled on the same edge; there is no coefficient shadow register.

## Timing
- Pipeline stages:
  - Stage 1 (edge k): register decoded coefficients and the pixel; form the nine products.
  - Stage 2 (edge k+1): register the three row sums.
  - Stage 3 (edge k+2): round, saturate and register Ro/Go/Bo.
- Latency: operands sampled at edge k appear on the outputs immediately after edge k+2. Throughput is one pixel per clock.
- Reset:
  - On any edge with rst = 1, all pipeline registers and Ro/Go/Bo clear to 0.
  - Reset asserted mid-stream discards all in-flight data.
  - After rst falls, outputs stay 0 until the first operand set sampled with rst = 0 reaches stage 3, which takes 3 edges.
- No X propagation: in-flight stages hold 0 until valid data arrives.

## Structure
- Shared package holds:
  - the default DSIZE/MSIZE/FRAC;
  - a function decoding sign-magnitude to two's complement;
  - the saturate function.
- Sub-module matrix_row_mac computes one row: three multipliers, a 3-input adder and round/saturate, pipelined identically. It is instantiated three times, one per output channel.
- The top level only fans coefficients and the pixel out to the rows.
- Clock/reset generation (clock_rst) lives in the bench only, not in this block.

## Test plan
All values at default parameters.
- Identity: M00 = M11 = M22 = 128, others 0, pixel (10, 20, 30) → (10, 20, 30) exactly 3 edges later.
- Negative saturation: all Mrc = 511 (−255), pixel (255, 255, 255) → S = −195075 → (0, 0, 0). Positive saturation: all Mrc = 255 → (255, 255, 255).
- Rounding and negative zero:
  - M00 = 64 (0.5), pixel (3, 0, 0) → Ro = 2.
  - M00 = 64, pixel (1, 0, 0) → Ro = 1.
  - M00 = 256 (−0), any pixel → Ro = 0.
- Channel mixing: M01 = 128, M10 = 128, M22 = 384 (−1.0), pixel (50, 100, 7) → (100, 50, 0).
- Random streaming: new random pixel and coefficients (0..511) every cycle for 10k cycles. Compare outputs against the reference formula delayed by exactly 3 cycles; no mismatch is allowed.
- Reset: assert rst for 1 cycle mid-stream. Outputs are 0 after that edge and remain 0 for 2 more edges, then track input sampled at the first post-reset edge.
